// File: rtl/spi_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_dmem_loader
// Brief    : Pulls address/data frames from an SPI receiver and writes them
//            into a data memory, with a per-word receive timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dmem_loader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W:0]   nwords_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [ADDR_W:0]   count_out,
    output logic              spi_read_out,
    input  logic              spi_ready_in,
    input  logic [DATA_W-1:0] spi_data_in,
    input  logic [ADDR_W-1:0] spi_addr_in,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out
);

    localparam int               WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_err   <= 1'b0;
                        r_count <= '0;
                        if (nwords_in != '0) begin
                            r_remaining <= nwords_in;
                            r_done      <= 1'b0;
                            r_wait      <= '0;
                            r_state     <= ST_RECV;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    // A frame arriving on the last allowed cycle beats the timeout.
                    if (spi_ready_in) begin
                        r_addr  <= spi_addr_in;
                        r_data  <= spi_data_in;
                        r_wait  <= '0;
                        r_state <= ST_WRITE;
                    end else if (r_wait == c_wait_last) begin
                        r_err   <= 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Always passes through here, giving the SPI side a read-low gap per frame.
                    r_remaining <= r_remaining - c_cnt_one;
                    r_count     <= r_count + c_cnt_one;
                    if (r_remaining == c_cnt_one) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out     = (r_state != ST_IDLE);
    assign spi_read_out = (r_state == ST_RECV);
    assign mem_we_out   = (r_state == ST_WRITE);
    assign done_out     = r_done;
    assign err_out      = r_err;
    assign count_out    = r_count;
    assign mem_addr_out = r_addr;
    assign mem_data_out = r_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_dmem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_dmem_loader
// Brief    : Randomized scoreboard bench for spi_dmem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_dmem_loader;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_in = 1'b0;
    logic [ADDR_W:0]   nwords_in = '0;
    logic              busy_out;
    logic              done_out;
    logic              err_out;
    logic [ADDR_W:0]   count_out;
    logic              spi_read_out;
    logic              spi_ready_in = 1'b0;
    logic [DATA_W-1:0] spi_data_in = '0;
    logic [ADDR_W-1:0] spi_addr_in = '0;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;

    spi_dmem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .nwords_in   (nwords_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .err_out     (err_out),
        .count_out   (count_out),
        .spi_read_out(spi_read_out),
        .spi_ready_in(spi_ready_in),
        .spi_data_in (spi_data_in),
        .spi_addr_in (spi_addr_in),
        .mem_we_out  (mem_we_out),
        .mem_addr_out(mem_addr_out),
        .mem_data_out(mem_data_out)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    logic [ADDR_W-1:0] adr[16];
    logic [DATA_W-1:0] dat[16];
    int                dly[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected frame, on the expected cycle.
    always @(negedge clk) begin
        if (mem_we_out !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                         mem_addr_out, mem_data_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr_out), 32'(mon_e.addr));
                check("wr_data", 32'(mem_data_out), 32'(mon_e.data));
                check("wr_cycle", cyc, mon_e.cyc);
                check("wr_read_low", 32'(spi_read_out), 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy_out), 0);
        check({tag, "_done"},  32'(done_out), 0);
        check({tag, "_err"},   32'(err_out), 0);
        check({tag, "_count"}, 32'(count_out), 0);
        check({tag, "_read"},  32'(spi_read_out), 0);
        check({tag, "_we"},    32'(mem_we_out), 0);
        check({tag, "_addr"},  32'(mem_addr_out), 0);
        check({tag, "_data"},  32'(mem_data_out), 0);
    endtask

    task automatic do_start(input int n);
        start_in  = 1'b1;
        nwords_in = n[ADDR_W:0];
        @(negedge clk);
        start_in  = 1'b0;
        nwords_in = (ADDR_W + 1)'($urandom);
        if (n != 0) begin
            check("start_busy",  32'(busy_out), 1);
            check("start_read",  32'(spi_read_out), 1);
            check("start_done",  32'(done_out), 0);
            check("start_err",   32'(err_out), 0);
            check("start_count", 32'(count_out), 0);
        end else begin
            check("zero_done",  32'(done_out), 1);
            check("zero_busy",  32'(busy_out), 0);
            check("zero_read",  32'(spi_read_out), 0);
            check("zero_err",   32'(err_out), 0);
            check("zero_count", 32'(count_out), 0);
        end
    endtask

    // Entered on the first cycle of a receive window; d is the number of idle cycles before ready.
    task automatic frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                         input int d, input int last, output int accepted);
        accepted = (d <= TIMEOUT - 1) ? 1 : 0;
        if (accepted != 0) begin
            for (int i = 0; i < d; i++) begin
                if (i == 0 && $urandom_range(0, 2) == 0) begin
                    start_in  = 1'b1;
                    nwords_in = (ADDR_W + 1)'($urandom);
                end
                spi_data_in = DATA_W'($urandom);
                spi_addr_in = ADDR_W'($urandom);
                @(negedge clk);
                start_in = 1'b0;
            end
            spi_ready_in = 1'b1;
            spi_data_in  = v;
            spi_addr_in  = a;
            exp_q.push_back('{a, v, cyc + 1});
            @(negedge clk);
            spi_ready_in = 1'b0;
            spi_data_in  = DATA_W'($urandom);
            spi_addr_in  = ADDR_W'($urandom);
            check("sep_read_low", 32'(spi_read_out), 0);
            @(negedge clk);
            check("next_read", 32'(spi_read_out), (last != 0) ? 0 : 1);
        end else begin
            repeat (TIMEOUT) @(negedge clk);
            check("to_read", 32'(spi_read_out), 0);
            check("to_busy", 32'(busy_out), 0);
            spi_ready_in = 1'b1;
            spi_data_in  = v;
            spi_addr_in  = a;
            @(negedge clk);
            spi_ready_in = 1'b0;
            check("late_ready_read", 32'(spi_read_out), 0);
        end
    endtask

    task automatic run_load(input int n);
        int exp_n;
        int timed_out;
        int acc;
        exp_n     = 0;
        timed_out = 0;
        do_start(n);
        for (int k = 0; k < n && timed_out == 0; k++) begin
            frame(adr[k], dat[k], dly[k], (k == n - 1) ? 1 : 0, acc);
            if (acc != 0) exp_n++;
            else timed_out = 1;
        end
        check("end_done",  32'(done_out), (timed_out != 0) ? 0 : 1);
        check("end_err",   32'(err_out), timed_out);
        check("end_count", 32'(count_out), exp_n);
        check("end_busy",  32'(busy_out), 0);
        check("sb_empty",  exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single word after 20 idle cycles
        adr[0] = 4'h3; dat[0] = 8'hA5; dly[0] = 20;
        run_load(1);

        // Full 16-word burst
        for (int i = 0; i < 16; i++) begin
            adr[i] = ADDR_W'(i);
            dat[i] = DATA_W'(8'h10 + i);
            dly[i] = $urandom_range(0, 3);
        end
        run_load(16);

        // Timeout on the second of two words
        adr[0] = 4'h7; dat[0] = 8'h5C; dly[0] = 2;
        adr[1] = 4'h8; dat[1] = 8'hC3; dly[1] = TIMEOUT + 6;
        run_load(2);

        // Zero-length load clears the earlier error and count
        do_start(0);
        repeat (3) begin
            @(negedge clk);
            check("zero_hold_read", 32'(spi_read_out), 0);
        end

        // Ready on the timeout cycle itself wins; one cycle later it does not
        adr[0] = 4'hE; dat[0] = 8'h3B; dly[0] = TIMEOUT - 1;
        run_load(1);
        adr[0] = 4'h1; dat[0] = 8'h77; dly[0] = TIMEOUT;
        run_load(1);

        // Reset during the third word of five
        for (int i = 0; i < 5; i++) begin
            adr[i] = ADDR_W'($urandom);
            dat[i] = DATA_W'($urandom);
        end
        do_start(5);
        frame(adr[0], dat[0], 1, 0, acc);
        frame(adr[1], dat[1], 0, 0, acc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        start_in     = 1'b1;
        nwords_in    = 5'd4;
        spi_ready_in = 1'b1;
        @(negedge clk);
        check_all_zero("rst_prio");
        rst          = 1'b0;
        start_in     = 1'b0;
        spi_ready_in = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy_out), 0);
        check("post_rst_done", 32'(done_out), 0);
        for (int i = 0; i < 2; i++) begin
            adr[i] = ADDR_W'($urandom);
            dat[i] = DATA_W'($urandom);
            dly[i] = $urandom_range(0, 4);
        end
        run_load(2);

        // Randomized loads with occasional boundary and timeout delays
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                adr[i] = ADDR_W'($urandom);
                dat[i] = DATA_W'($urandom);
                r = $urandom_range(0, 19);
                dly[i] = (r == 0) ? TIMEOUT + 6 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            end
            run_load($urandom_range(1, 16));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("final_sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
